stream_pool_unit: RTL and testbench
===================================

Name: stream_pool_unit

Overview:
- Sequential, parametrised successor to the combinational pooling layer.
- Accepts a raster-ordered feature map one pixel per beat (all channels in parallel) over a valid/ready handshake.
- Keeps per-window partial results in a row accumulator buffer and emits one pooled word per channel per completed POOL x POOL window.
- Runtime-selectable max or average mode; sits between convolution output and the next layer's input stream.

Parameters:
DATA_W, 32, signed two's-complement sample width (Q16.15 in current datapath).
IMG_SIZE, 8, square feature map side length in pixels.
POOL, 2, window side; power of two, 2..IMG_SIZE; non-overlapping stride = POOL.
CHANNELS, 1, channels processed in parallel, packed channel 0 in LSBs.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
mode  input  1  0 = max pool, 1 = average pool; sampled at frame start.
clear  input  1  synchronous frame abort: zero counters, drop partials, deassert out_valid.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a pixel this cycle.
in_data  input  CHANNELS*DATA_W  one pixel, all channels.
out_valid  output  1  out_data holds a pooled result.
out_ready  input  1  downstream accepts out_data.
out_data  output  CHANNELS*DATA_W  pooled result, all channels.
out_last  output  1  qualifies final pooled word of a frame.
frame_done  output  1  one-cycle pulse when out_last beat is accepted.

Behaviour:
- Reset (async assert, sync release): row/col counters 0, out_valid 0, out_data 0, out_last 0, frame_done 0, mode latch 0. Accumulator contents don't-care.
- Transfer rules:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - in_ready = !out_valid | out_ready, combinational; no skid buffer.
  - While out_valid=1, out_data and out_last stay stable until transferred.
- Pixel position:
  - Counters col (0..IMG_SIZE-1) and row advance per input transfer.
  - col wraps to 0 and row increments; row wraps to 0 after (IMG_SIZE-1, IMG_SIZE-1).
- mode handling: latched on input transfer at (0,0); changes mid-frame are ignored until the next frame.
- Active region:
  - Pixel is active only if row < P and col < P, where P = (IMG_SIZE/POOL)*POOL.
  - Inactive pixels (trailing rows/cols when not divisible) are accepted and discarded.
- Window handling:
  - Window index w = col/POOL; accumulator buffer has IMG_SIZE/POOL entries per channel.
  - First pixel of window (row%POOL==0 and col%POOL==0): load entry. Max loads the sample; avg loads the sign-extended sample.
  - Other pixels: max combines with signed compare, keeping the larger; avg adds.
  - Accumulator width is DATA_W + 2*log2(POOL). No overflow is possible.
- Emission:
  - Last pixel of window (row%POOL==POOL-1 and col%POOL==POOL-1): result computed from the entry combined with the current pixel.
  - Result registered into out_data with out_valid=1 on the cycle after the input transfer (latency 1).
  - Avg result = sum arithmetic-shifted right by 2*log2(POOL), floor rounding, truncated to DATA_W (always fits).
  - out_last=1 when the window is the bottom-right active window.
- Simultaneous events:
  - Output transfer and new emission in the same cycle: out_valid stays 1 and data is replaced.
  - Output transfer with no new emission: out_valid goes to 0.
- clear: has priority over input transfer the same cycle; in_ready is still reported but the pixel is dropped.
- Reset mid-frame: everything returns to reset state; the next accepted pixel is (0,0).
- Channels are independent; identical control for all channels.

Test Plan:
- IMG_SIZE=4, POOL=2, DATA_W=16, mode=0, inputs 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last only on 15; frame_done pulse; each output 1 cycle after its window's last pixel.
- Same stimulus, mode=1 -> outputs 2,4,10,12 (floor of 2.5, 4.5, 10.5, 12.5).
- Single window of -1,-2,-3,-4 -> max output -1 (0xFFFF); avg output -3 (floor -2.5).
- out_ready=0 for 5 cycles while a result is pending -> in_ready=0, out_data stable, no input lost; after release, the remaining sequence matches the first scenario.
- IMG_SIZE=5, POOL=2, inputs 0..24 -> max outputs 6,8,16,18; row 4 and col 4 are consumed without output; out_last on 18.
- Assert rst_n=0 (or clear=1) after 6 pixels, then send a full frame 0..15 -> outputs exactly 5,7,13,15; mode toggled mid-frame has no effect until the next frame.

Source files
------------

// File: rtl/stream_pool_unit.sv
// stream_pool_unit
// Streaming POOL x POOL pooling (max or average) over a raster-ordered
// feature map. Takes one pixel per beat (all channels in parallel) and keeps
// one partial result per window column in a row accumulator buffer. Each
// completed window produces one registered output word.
//
// Ports
//   clk, rst_n          rising-edge clock, async active-low reset
//   mode                0 = max, 1 = average (taken at pixel (0,0))
//   clear               synchronous frame abort
//   in_valid/in_ready   input handshake, in_data = one pixel, all channels
//   out_valid/out_ready output handshake, out_data = pooled word
//   out_last            marks the bottom-right window of the frame
//   frame_done          high in the cycle the out_last beat is accepted
module stream_pool_unit #(
  parameter int DATA_W   = 32,
  parameter int IMG_SIZE = 8,
  parameter int POOL     = 2,
  parameter int CHANNELS = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_last,
  output logic                         frame_done
);

  localparam int LOG2P = $clog2(POOL);
  localparam int SHIFT = 2 * LOG2P;
  localparam int ACC_W = DATA_W + SHIFT;
  localparam int NWIN  = IMG_SIZE / POOL;
  localparam int P_ACT = NWIN * POOL;
  localparam int CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

  logic [CNT_W-1:0]          row_q, row_d, col_q, col_d;
  logic                      mode_q, mode_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [CHANNELS*DATA_W-1:0] out_data_q, out_data_d;

  logic                      in_xfer, out_xfer, pix_take;
  logic                      frame_start, mode_eff;
  logic                      active, win_first, win_last, last_win, emit;
  logic [CNT_W-1:0]          row_sub, col_sub;
  logic [WIN_W-1:0]          win_idx;
  logic [CHANNELS*DATA_W-1:0] result;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  // clear wins over a simultaneous input beat: the pixel is dropped
  assign pix_take  = in_xfer && !clear;

  // POOL is a power of two, so position within a window is a mask
  assign row_sub     = row_q & CNT_W'(POOL - 1);
  assign col_sub     = col_q & CNT_W'(POOL - 1);
  assign win_idx     = WIN_W'(col_q >> LOG2P);
  assign frame_start = (row_q == '0) && (col_q == '0);
  // the pixel at (0,0) already uses the mode it latches
  assign mode_eff    = frame_start ? mode : mode_q;

  // compare as int so P_ACT == IMG_SIZE does not wrap in CNT_W bits
  assign active    = (int'(row_q) < P_ACT) && (int'(col_q) < P_ACT);
  assign win_first = (row_sub == '0) && (col_sub == '0);
  assign win_last  = (row_sub == CNT_W'(POOL - 1)) && (col_sub == CNT_W'(POOL - 1));
  assign last_win  = (int'(row_q) == P_ACT - 1) && (int'(col_q) == P_ACT - 1);
  assign emit      = pix_take && active && win_last;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [ACC_W-1:0] acc_q [NWIN];
    logic signed [ACC_W-1:0] sample, entry, combined;

    assign sample   = {{SHIFT{in_data[c*DATA_W + DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
    assign entry    = acc_q[win_idx];
    assign combined = mode_eff ? (entry + sample) : ((sample > entry) ? sample : entry);
    assign result[c*DATA_W +: DATA_W] = mode_eff ? DATA_W'(combined >>> SHIFT)
                                                 : combined[DATA_W-1:0];

    // partial results are don't-care after reset; the first pixel of
    // every window overwrites its entry
    always_ff @(posedge clk) begin
      if (pix_take && active) begin
        acc_q[win_idx] <= win_first ? sample : combined;
      end
    end
  end

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    mode_d = mode_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (in_xfer) begin
      if (frame_start) mode_d = mode;
      if (col_q == CNT_W'(IMG_SIZE - 1)) begin
        col_d = '0;
        row_d = (row_q == CNT_W'(IMG_SIZE - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (emit) begin
      // also covers a same-cycle output transfer: the new word replaces it
      out_valid_d = 1'b1;
      out_last_d  = last_win;
      out_data_d  = result;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = out_xfer && out_last_q;

endmodule

// File: tb/tb_stream_pool_unit.sv
module tb_stream_pool_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4x4, POOL 2, 16-bit ; DUT B: 5x5, POOL 2, 16-bit
  logic        a_mode, a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_frame_done;
  logic [15:0] a_in_data, a_out_data;
  logic        b_mode, b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
  logic [15:0] b_in_data, b_out_data;

  stream_pool_unit #(.DATA_W(16), .IMG_SIZE(4), .POOL(2), .CHANNELS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .frame_done(a_frame_done));

  stream_pool_unit #(.DATA_W(16), .IMG_SIZE(5), .POOL(2), .CHANNELS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .frame_done(b_frame_done));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          a_in_cnt, b_in_cnt;
  int          a_in_cyc[$], b_in_cyc[$];
  logic [15:0] a_got[$], b_got[$];
  bit          a_got_last[$], b_got_last[$];
  int          a_got_cyc[$], b_got_cyc[$];
  int          a_fd_cnt, a_fd_cyc, b_fd_cnt, b_fd_cyc;

  task automatic clear_logs();
    a_in_cnt = 0; b_in_cnt = 0;
    a_in_cyc.delete(); b_in_cyc.delete();
    a_got.delete(); b_got.delete();
    a_got_last.delete(); b_got_last.delete();
    a_got_cyc.delete(); b_got_cyc.delete();
    a_fd_cnt = 0; a_fd_cyc = -1; b_fd_cnt = 0; b_fd_cyc = -1;
  endtask

  // Inputs are driven 1 time unit after a rising edge; this samples the
  // handshakes that the next edge will complete, then advances one cycle.
  task automatic tick();
    #1;
    if (a_in_valid && a_in_ready) begin a_in_cnt++; a_in_cyc.push_back(cyc); end
    if (a_out_valid && a_out_ready) begin
      a_got.push_back(a_out_data); a_got_last.push_back(a_out_last); a_got_cyc.push_back(cyc);
    end
    if (a_frame_done) begin a_fd_cnt++; a_fd_cyc = cyc; end
    if (b_in_valid && b_in_ready) begin b_in_cnt++; b_in_cyc.push_back(cyc); end
    if (b_out_valid && b_out_ready) begin
      b_got.push_back(b_out_data); b_got_last.push_back(b_out_last); b_got_cyc.push_back(cyc);
    end
    if (b_frame_done) begin b_fd_cnt++; b_fd_cyc = cyc; end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input bit sel, input logic [15:0] v, input logic m);
    int start;
    start = sel ? b_in_cnt : a_in_cnt;
    if (sel) begin b_in_valid = 1'b1; b_in_data = v; b_mode = m; end
    else     begin a_in_valid = 1'b1; a_in_data = v; a_mode = m; end
    for (int t = 0; t < 50; t++) begin
      if ((sel ? b_in_cnt : a_in_cnt) != start) break;
      tick();
    end
    if ((sel ? b_in_cnt : a_in_cnt) == start) begin
      checks++; failures++;
      $display("FAIL send_timeout dut=%0d value=%0d not accepted within 50 cycles", sel, v);
    end
    if (sel) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  // m0 is the mode shown on pixel (0,0); m1 is shown on every other pixel
  task automatic send_frame(input bit sel, input logic [15:0] vals [25], input int n,
                            input logic m0, input logic m1);
    for (int i = 0; i < n; i++) send(sel, vals[i], (i == 0) ? m0 : m1);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 16'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", a_out_data); end
    checks++; if (a_out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", a_out_last); end
    checks++; if (a_frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", a_frame_done); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", a_in_ready); end
    checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL rst_b_out_valid got=%b exp=0", b_out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    logic [15:0] vals [25];
    int exp_v [4] = '{5, 7, 13, 15};
    for (int i = 0; i < 25; i++) vals[i] = 16'(i);
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b0, 1'b0);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL max_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_v[i])) begin failures++; $display("FAIL max_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_v[i]); end
      checks++; if (a_got_last[i] !== (i == 3)) begin failures++; $display("FAIL max_last[%0d] got=%b exp=%b", i, a_got_last[i], (i == 3)); end
      checks++; if (a_got_cyc[i] != a_in_cyc[exp_v[i]] + 1) begin
        failures++; $display("FAIL max_latency[%0d] got=%0d exp=%0d", i, a_got_cyc[i], a_in_cyc[exp_v[i]] + 1);
      end
    end
    checks++; if (a_fd_cnt != 1) begin failures++; $display("FAIL max_frame_done_count got=%0d exp=1", a_fd_cnt); end
    if (a_got.size() == 4) begin
      checks++; if (a_fd_cyc != a_got_cyc[3]) begin failures++; $display("FAIL max_frame_done_cycle got=%0d exp=%0d", a_fd_cyc, a_got_cyc[3]); end
    end
  endtask

  task automatic test_avg();
    logic [15:0] vals [25];
    int exp_v [4] = '{2, 4, 10, 12};
    for (int i = 0; i < 25; i++) vals[i] = 16'(i);
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b1, 1'b1);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL avg_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_v[i])) begin failures++; $display("FAIL avg_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_v[i]); end
      checks++; if (a_got_last[i] !== (i == 3)) begin failures++; $display("FAIL avg_last[%0d] got=%b exp=%b", i, a_got_last[i], (i == 3)); end
    end
  endtask

  task automatic test_negative();
    logic [15:0] vals [25];
    for (int i = 0; i < 25; i++) vals[i] = 16'h0000;
    vals[0] = 16'hFFFF; vals[1] = 16'hFFFE; vals[4] = 16'hFFFD; vals[5] = 16'hFFFC;
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b0, 1'b0);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL neg_max_count got=%0d exp=4", a_got.size()); end
    if (a_got.size() > 1) begin
      checks++; if (a_got[0] !== 16'hFFFF) begin failures++; $display("FAIL neg_max_data got=%h exp=ffff", a_got[0]); end
      checks++; if (a_got[1] !== 16'h0000) begin failures++; $display("FAIL neg_max_zero_win got=%h exp=0000", a_got[1]); end
    end
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b1, 1'b1);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL neg_avg_count got=%0d exp=4", a_got.size()); end
    if (a_got.size() > 0) begin
      checks++; if (a_got[0] !== 16'hFFFD) begin failures++; $display("FAIL neg_avg_data got=%h exp=fffd", a_got[0]); end
    end
  endtask

  task automatic test_backpressure();
    int exp_v [4] = '{5, 7, 13, 15};
    clear_logs();
    for (int i = 0; i < 5; i++) send(1'b0, 16'(i), 1'b0);
    a_out_ready = 1'b0;
    send(1'b0, 16'd5, 1'b0);
    a_in_valid = 1'b1; a_in_data = 16'd6; a_mode = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", k, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 16'd5) begin
        failures++; $display("FAIL stall_out[%0d] got valid=%b data=%0d exp valid=1 data=5", k, a_out_valid, a_out_data);
      end
    end
    checks++; if (a_in_cnt != 6) begin failures++; $display("FAIL stall_in_count got=%0d exp=6", a_in_cnt); end
    a_out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send(1'b0, 16'(i), 1'b0);
    repeat (3) tick();
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL stall_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_v[i])) begin failures++; $display("FAIL stall_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_v[i]); end
    end
  endtask

  task automatic test_img5();
    logic [15:0] vals [25];
    int exp_v [4] = '{6, 8, 16, 18};
    for (int i = 0; i < 25; i++) vals[i] = 16'(i);
    clear_logs();
    send_frame(1'b1, vals, 25, 1'b0, 1'b0);
    checks++; if (b_in_cnt != 25) begin failures++; $display("FAIL img5_in_count got=%0d exp=25", b_in_cnt); end
    checks++; if (b_got.size() != 4) begin failures++; $display("FAIL img5_count got=%0d exp=4", b_got.size()); end
    for (int i = 0; i < 4 && i < b_got.size(); i++) begin
      checks++; if (b_got[i] !== 16'(exp_v[i])) begin failures++; $display("FAIL img5_data[%0d] got=%0d exp=%0d", i, b_got[i], exp_v[i]); end
      checks++; if (b_got_last[i] !== (i == 3)) begin failures++; $display("FAIL img5_last[%0d] got=%b exp=%b", i, b_got_last[i], (i == 3)); end
      checks++; if (b_got_cyc[i] != b_in_cyc[exp_v[i]] + 1) begin
        failures++; $display("FAIL img5_latency[%0d] got=%0d exp=%0d", i, b_got_cyc[i], b_in_cyc[exp_v[i]] + 1);
      end
    end
    checks++; if (b_fd_cnt != 1) begin failures++; $display("FAIL img5_frame_done got=%0d exp=1", b_fd_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] vals [25];
    int exp_v [4] = '{5, 7, 13, 15};
    for (int i = 0; i < 25; i++) vals[i] = 16'(i);
    clear_logs();
    for (int i = 0; i < 5; i++) send(1'b0, 16'(50 + i), 1'b1);
    a_out_ready = 1'b0;
    send(1'b0, 16'd55, 1'b1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%b exp=1", a_out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 16'h0) begin
      failures++; $display("FAIL rmid_async got valid=%b data=%h exp valid=0 data=0000", a_out_valid, a_out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b0, 1'b0);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL rmid_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_v[i])) begin failures++; $display("FAIL rmid_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_v[i]); end
    end
  endtask

  task automatic test_clear_mode();
    logic [15:0] vals [25];
    int exp_max [4] = '{5, 7, 13, 15};
    int exp_avg [4] = '{2, 4, 10, 12};
    for (int i = 0; i < 25; i++) vals[i] = 16'(i);
    clear_logs();
    for (int i = 0; i < 5; i++) send(1'b0, 16'(100 + i), 1'b1);
    a_out_ready = 1'b0;
    send(1'b0, 16'd105, 1'b1);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL clr_pending got=%b exp=1", a_out_valid); end
    a_clear = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL clr_out_valid got=%b exp=0", a_out_valid); end
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 16'd999; a_mode = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL clr_in_ready got=%b exp=1", a_in_ready); end
    @(posedge clk); #1;
    a_clear = 1'b0; a_in_valid = 1'b0;
    clear_logs();
    // mode 0 at the frame start, then toggled high for the rest of the frame
    send_frame(1'b0, vals, 16, 1'b0, 1'b1);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL clr_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_max[i])) begin failures++; $display("FAIL clr_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_max[i]); end
    end
    clear_logs();
    send_frame(1'b0, vals, 16, 1'b1, 1'b0);
    checks++; if (a_got.size() != 4) begin failures++; $display("FAIL mode_next_count got=%0d exp=4", a_got.size()); end
    for (int i = 0; i < 4 && i < a_got.size(); i++) begin
      checks++; if (a_got[i] !== 16'(exp_avg[i])) begin failures++; $display("FAIL mode_next_data[%0d] got=%0d exp=%0d", i, a_got[i], exp_avg[i]); end
    end
  endtask

  initial begin
    a_mode = 1'b0; a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_mode = 1'b0; b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    clear_logs();
    test_reset();
    test_max();
    test_avg();
    test_negative();
    test_backpressure();
    test_img5();
    test_reset_mid();
    test_clear_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
